// File: rtl/da_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master drives operands and result acceptance; the slave is the divider.
interface da_divider_if #(
  parameter int ASIZE = 16,
  parameter int BSIZE = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [ASIZE-1:0] adata;
  logic [BSIZE-1:0] bdata;
  logic             out_valid;
  logic             out_ready;
  logic [ASIZE-1:0] qdata;
  logic [BSIZE-1:0] rdata;
  logic             div_zero;

  modport master (
    output in_valid, adata, bdata, out_ready,
    input  in_ready, out_valid, qdata, rdata, div_zero
  );

  modport slave (
    input  in_valid, adata, bdata, out_ready,
    output in_ready, out_valid, qdata, rdata, div_zero
  );
endinterface

// File: rtl/da_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both the operand and the result side.
module da_divider #(
  parameter int ASIZE = 16,
  parameter int BSIZE = 8,
  parameter int CSIZE = 5
) (
  input logic          clock,
  input logic          rst_n,
  da_divider_if.slave  bus
);

  if (ASIZE < BSIZE || BSIZE < 2 || (2 ** CSIZE) <= ASIZE) begin : g_bad_param
    $error("PARAM is wrong");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx;
  logic [ASIZE-1:0] dividend_r, dividend_nx;
  logic [BSIZE-1:0] divisor_r, divisor_nx;
  logic [BSIZE-1:0] rem_r, rem_nx;
  logic [CSIZE-1:0] cnt_r, cnt_nx;
  logic [ASIZE-1:0] qdata_r, qdata_nx;
  logic [BSIZE-1:0] rdata_r, rdata_nx;
  logic             div_zero_r, div_zero_nx;
  logic             out_valid_r, out_valid_nx;
  logic             in_ready_r, in_ready_nx;
  logic [BSIZE:0]   rem_shift_s;

  // The stored remainder always stays below the divisor, so BSIZE bits hold
  // it; the shifted trial value needs the extra bit for the compare.
  assign rem_shift_s = {rem_r, dividend_r[ASIZE-1]};

  // Next-state, datapath step and next registered-output values.
  always_comb begin
    state_nx     = state_r;
    dividend_nx  = dividend_r;
    divisor_nx   = divisor_r;
    rem_nx       = rem_r;
    cnt_nx       = cnt_r;
    qdata_nx     = qdata_r;
    rdata_nx     = rdata_r;
    div_zero_nx  = div_zero_r;
    out_valid_nx = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          dividend_nx = bus.adata;
          divisor_nx  = bus.bdata;
          rem_nx      = '0;
          cnt_nx      = CSIZE'(ASIZE - 1);
          if (bus.bdata == '0) begin
            state_nx    = DONE;
            qdata_nx    = '1;
            rdata_nx    = '0;
            div_zero_nx = 1'b1;
          end else begin
            state_nx = CALC;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        // Quotient bits shift into the low end as dividend bits leave the top.
        if (rem_shift_s >= {1'b0, divisor_r}) begin
          rem_nx      = BSIZE'(rem_shift_s - {1'b0, divisor_r});
          dividend_nx = {dividend_r[ASIZE-2:0], 1'b1};
        end else begin
          rem_nx      = rem_shift_s[BSIZE-1:0];
          dividend_nx = {dividend_r[ASIZE-2:0], 1'b0};
        end
        if (cnt_r == '0) begin
          state_nx    = DONE;
          cnt_nx      = '0;
          qdata_nx    = dividend_nx;
          rdata_nx    = rem_nx;
          div_zero_nx = 1'b0;
        end else begin
          state_nx = CALC;
          cnt_nx   = cnt_r - CSIZE'(1);
        end
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          state_nx     = IDLE;
          out_valid_nx = 1'b0;
        end else begin
          state_nx     = DONE;
          out_valid_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    in_ready_nx = (state_nx == IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      dividend_r  <= '0;
      divisor_r   <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      qdata_r     <= '0;
      rdata_r     <= '0;
      div_zero_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx;
      dividend_r  <= dividend_nx;
      divisor_r   <= divisor_nx;
      rem_r       <= rem_nx;
      cnt_r       <= cnt_nx;
      qdata_r     <= qdata_nx;
      rdata_r     <= rdata_nx;
      div_zero_r  <= div_zero_nx;
      out_valid_r <= out_valid_nx;
      in_ready_r  <= in_ready_nx;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.qdata     = qdata_r;
  assign bus.rdata     = rdata_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_da_divider.sv
// Self-checking bench for da_divider: a cycle-counting behavioural model
// checked every cycle, plus directed literal cases and a random sweep.
module tb_da_divider;
  localparam int ASIZE = 16;
  localparam int BSIZE = 8;
  localparam int CSIZE = 5;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  da_divider_if #(.ASIZE(ASIZE), .BSIZE(BSIZE)) bus ();

  da_divider #(.ASIZE(ASIZE), .BSIZE(BSIZE), .CSIZE(CSIZE)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: result = a/b, a%b (or the zero-divisor rule), shown
  // after a fixed number of cycles counted from the accept edge.
  typedef enum int {M_IDLE, M_BUSY, M_SHOW} mphase_t;
  mphase_t          m_phase = M_IDLE;
  int               m_cnt = 0;
  bit               m_live = 1'b0;
  logic [ASIZE-1:0] m_a, exp_q;
  logic [BSIZE-1:0] m_b, exp_r;
  logic             exp_dz, exp_valid, exp_ready;

  always @(posedge clock) begin
    if (!rst_n) begin
      m_live    <= 1'b1;
      m_phase   <= M_IDLE;
      m_cnt     <= 0;
      exp_q     <= '0;
      exp_r     <= '0;
      exp_dz    <= 1'b0;
      exp_valid <= 1'b0;
      exp_ready <= 1'b1;
    end else begin
      case (m_phase)
        M_IDLE: if (bus.in_valid) begin
          m_phase   <= M_BUSY;
          exp_ready <= 1'b0;
          m_a       <= bus.adata;
          m_b       <= bus.bdata;
          if (bus.bdata == 8'd0) begin
            m_cnt  <= 1;
            exp_q  <= 16'hFFFF;
            exp_r  <= 8'd0;
            exp_dz <= 1'b1;
          end else begin
            m_cnt  <= ASIZE + 1;
            exp_q  <= bus.adata / {8'd0, bus.bdata};
            exp_r  <= 8'(bus.adata % {8'd0, bus.bdata});
            exp_dz <= 1'b0;
          end
        end
        M_BUSY: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_phase   <= M_SHOW;
            exp_valid <= 1'b1;
          end
        end
        M_SHOW: if (bus.out_ready) begin
          m_phase   <= M_IDLE;
          exp_valid <= 1'b0;
          exp_ready <= 1'b1;
        end
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clock) begin
    if (m_live) begin
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (m_phase != M_BUSY) begin
        check("qdata", 32'(bus.qdata), 32'(exp_q));
        check("rdata", 32'(bus.rdata), 32'(exp_r));
        check("div_zero", 32'(bus.div_zero), 32'(exp_dz));
      end
      if (exp_valid && !exp_dz) begin
        check("invariant", 32'(bus.qdata) * 32'(m_b) + 32'(bus.rdata), 32'(m_a));
        check("rem_lt_div", 32'(bus.rdata < m_b), 32'd1);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit rnd, output int lat);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clock);
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_in_ready: timed out after %0d cycles, required in_ready=1", guard);
    end
    bus.in_valid = 1'b1;
    bus.adata    = a;
    bus.bdata    = b;
    @(negedge clock);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
      if (rnd) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.adata     = 16'($urandom);
        bus.bdata     = 8'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    if (lat >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_out_valid: timed out after %0d cycles, required out_valid=1", lat);
    end
  endtask

  initial begin
    int lat;
    logic [15:0] ra;
    logic [7:0]  rb;
    bus.in_valid  = 1'b0;
    bus.adata     = 16'd0;
    bus.bdata     = 8'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_qdata", 32'(bus.qdata), 32'd0);

    run_op(16'd1000, 8'd7, 1'b0, lat);
    check("lat_1000_7", 32'(lat), 32'd17);
    check("q_1000_7", 32'(bus.qdata), 32'd142);
    check("r_1000_7", 32'(bus.rdata), 32'd6);
    check("dz_1000_7", 32'(bus.div_zero), 32'd0);
    @(negedge clock);
    check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);

    run_op(16'd65535, 8'd255, 1'b0, lat);
    check("q_65535_255", 32'(bus.qdata), 32'd257);
    check("r_65535_255", 32'(bus.rdata), 32'd0);
    run_op(16'd5, 8'd9, 1'b0, lat);
    check("q_5_9", 32'(bus.qdata), 32'd0);
    check("r_5_9", 32'(bus.rdata), 32'd5);
    run_op(16'd40000, 8'd1, 1'b0, lat);
    check("q_40000_1", 32'(bus.qdata), 32'd40000);
    check("r_40000_1", 32'(bus.rdata), 32'd0);

    run_op(16'd1234, 8'd0, 1'b0, lat);
    check("lat_div0", 32'(lat), 32'd1);
    check("q_div0", 32'(bus.qdata), 32'hFFFF);
    check("r_div0", 32'(bus.rdata), 32'd0);
    check("dz_div0", 32'(bus.div_zero), 32'd1);
    run_op(16'd100, 8'd10, 1'b0, lat);
    check("q_100_10", 32'(bus.qdata), 32'd10);
    check("r_100_10", 32'(bus.rdata), 32'd0);
    check("dz_100_10", 32'(bus.div_zero), 32'd0);
    @(negedge clock);

    // Stalled result with operands offered during the stall.
    bus.out_ready = 1'b0;
    run_op(16'd300, 8'd17, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.adata    = 16'd9;
      bus.bdata    = 8'd3;
      @(negedge clock);
      check("stall_q", 32'(bus.qdata), 32'd17);
      check("stall_r", 32'(bus.rdata), 32'd11);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("stall_not_consumed", 32'(bus.out_valid), 32'd0);
    check("retain_q", 32'(bus.qdata), 32'd17);

    // Reset in the middle of a calculation.
    bus.in_valid = 1'b1;
    bus.adata    = 16'd50000;
    bus.bdata    = 8'd200;
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_q", 32'(bus.qdata), 32'd0);
    check("midrst_r", 32'(bus.rdata), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(16'd50000, 8'd200, 1'b0, lat);
    check("lat_50000_200", 32'(lat), 32'd17);
    check("q_50000_200", 32'(bus.qdata), 32'd250);
    check("r_50000_200", 32'(bus.rdata), 32'd0);

    // Random sweep with backpressure and junk operands while busy.
    for (int n = 0; n < 1500; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 8'd0;
        1:       rb = 8'd1;
        2:       rb = 8'd255;
        3:       begin rb = 8'($urandom); ra = 16'hFFFF; end
        default: rb = 8'($urandom);
      endcase
      run_op(ra, rb, 1'b1, lat);
    end
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
